// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: byte strobes, lane alignment, two-beat split, load extension
// Optional feature macro: MEM_MISALIGN_SPLIT_EN (misaligned accesses performed instead of trapping)
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    output logic                stall,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                exc_adel,
    output logic                exc_ades,
    output logic                bus_valid,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ready,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

`ifdef MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t             state;
    logic [OFF_W-1:0]   off_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [NB-1:0]      be_hi_q;
    logic [DATA_W-1:0]  beat0_q;

    // Strobes over two consecutive bus words: lanes [off, off+bytes) set.
    function automatic logic [2*NB-1:0] make_be(input logic [OFF_W-1:0] o, input logic [1:0] sz);
        logic [4:0]        lo;
        logic [4:0]        hi;
        logic [2*NB-1:0]   be;
        lo = 5'(o);
        hi = lo + (5'd1 << sz);
        for (int i = 0; i < 2*NB; i++) begin
            be[i] = (5'(i) >= lo) && (5'(i) < hi);
        end
        return be;
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [2*DATA_W-1:0] d, input logic [OFF_W-1:0] o,
                                                 input logic [1:0] sz, input logic sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic              sb;
        sh = DATA_W'(d >> {o, 3'b000});
        case (sz)
            2'd0:    begin mask = DATA_W'(8'hFF);         sb = sh[7];        end
            2'd1:    begin mask = DATA_W'(16'hFFFF);      sb = sh[15];       end
            2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sb = sh[31];       end
            default: begin mask = '1;                     sb = sh[DATA_W-1]; end
        endcase
        return (sh & mask) | (~mask & {DATA_W{sgn & sb}});
    endfunction

    logic [OFF_W-1:0]   req_off;
    logic [3:0]         size_mask;
    logic               misaligned;
    logic               illegal;
    logic               req_exc;
    logic [2*NB-1:0]    req_be;
    logic [2*DATA_W-1:0] wshift;
    logic [DATA_W-1:0]  req_wrot;
    logic [DATA_W-1:0]  load_data;

    always_comb begin
        req_off    = req_addr[OFF_W-1:0];
        size_mask  = (4'd1 << req_size) - 4'd1;
        misaligned = ({1'b0, req_addr[2:0]} & size_mask) != 4'd0;
        illegal    = (req_size == 2'b11) && (NB == 4);
        req_exc    = illegal | (misaligned & ~SPLIT_EN);
        req_be     = make_be(req_off, req_size);
        // Rotate left by off bytes: bits pushed past the top wrap to the bottom lanes.
        wshift     = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
        req_wrot   = wshift[DATA_W-1:0] | wshift[2*DATA_W-1:DATA_W];
        load_data  = extend((state == BEAT1) ? {bus_rdata, beat0_q} : {{DATA_W{1'b0}}, bus_rdata},
                            off_q, size_q, signed_q);
    end

    assign stall = req_valid & ~rsp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            off_q     <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            be_hi_q   <= '0;
            beat0_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        off_q     <= req_off;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        be_hi_q   <= req_be[2*NB-1:NB];
                        if (req_exc) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            exc_adel  <= ~req_we;
                            exc_ades  <= req_we;
                        end else begin
                            state     <= BEAT0;
                            bus_valid <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= req_addr & ~ADDR_W'(NB-1);
                            bus_be    <= req_be[NB-1:0];
                            bus_wdata <= req_we ? req_wrot : '0;
                        end
                    end
                end
                BEAT0: begin
                    if (bus_ready) begin
                        if (SPLIT_EN && (be_hi_q != '0)) begin
                            state    <= BEAT1;
                            bus_addr <= bus_addr + ADDR_W'(NB);
                            bus_be   <= be_hi_q;
                            beat0_q  <= bus_rdata;
                        end else begin
                            state     <= RESP;
                            bus_valid <= 1'b0;
                            bus_be    <= '0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= bus_we ? '0 : load_data;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ready) begin
                        state     <= RESP;
                        bus_valid <= 1'b0;
                        bus_be    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= bus_we ? '0 : load_data;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    exc_adel  <= 1'b0;
                    exc_ades  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (DATA_W=32)
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        int          lat;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    waited = 0;
    int    cyc = 0;
    int    acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        beat_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.rdata = rdata; b.waits = waits;
        beat_q.push_back(b);
    endtask

    task automatic exp_rsp(input logic [31:0] rdata, input logic adel, input logic ades, input int lat);
        rsp_t r;
        r.rdata = rdata; r.adel = adel; r.ades = ades; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !reset) acc_cyc <= cyc + 1;
    end

    // Bus responder and beat checker: every valid cycle is compared, so stalled beats must hold steady.
    always @(negedge clk) begin
        if (bus_valid) begin
            if (beat_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_beat: got addr %h be %b expected no bus activity", bus_addr, bus_be);
                bus_ready = 1'b1;
            end else begin
                chk("bus_we", {31'd0, bus_we}, {31'd0, beat_q[0].we});
                chk("bus_addr", bus_addr, beat_q[0].addr);
                chk("bus_be", {28'd0, bus_be}, {28'd0, beat_q[0].be});
                chk("bus_wdata", bus_wdata, beat_q[0].wdata);
                bus_rdata = beat_q[0].rdata;
                if (waited < beat_q[0].waits) begin
                    bus_ready = 1'b0;
                    waited++;
                end else begin
                    bus_ready = 1'b1;
                    waited = 0;
                    void'(beat_q.pop_front());
                end
            end
        end else begin
            bus_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_rsp: got rsp_valid with rdata %h expected none", rsp_rdata);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, r.rdata);
                chk("exc_adel", {31'd0, exc_adel}, {31'd0, r.adel});
                chk("exc_ades", {31'd0, exc_ades}, {31'd0, r.ades});
                chk("rsp_latency", 32'(cyc - acc_cyc + 1), 32'(r.lat));
            end
        end
    end

    task automatic start_req(input logic we, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            chk("stall_held", {31'd0, stall}, 32'd1);
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 100 cycles");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
        start_req(we, sz, sgn, addr, wdata);
        wait_rsp();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_bus_be", {28'd0, bus_be}, 32'd0);
        chk("reset_stall_lo", {31'd0, stall}, 32'd0);
        req_valid = 1'b1;
        #1 chk("reset_stall_hi", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        exp_beat(1, 32'h1000, 4'b1000, 32'hAB00_0000, 32'h0, 0);
        exp_rsp(32'h0, 0, 0, 2);
        run(1, 2'd0, 0, 32'h1003, 32'h0000_00AB);

        exp_beat(0, 32'h2000, 4'b1100, 32'h0, 32'h8001_1234, 0);
        exp_rsp(32'hFFFF_8001, 0, 0, 2);
        run(0, 2'd1, 1, 32'h2002, 32'h0);

        exp_beat(0, 32'h2000, 4'b1100, 32'h0, 32'h8001_1234, 0);
        exp_rsp(32'h0000_8001, 0, 0, 2);
        run(0, 2'd1, 0, 32'h2002, 32'h0);

        exp_beat(0, 32'h2000, 4'b0010, 32'h0, 32'h1234_8056, 0);
        exp_rsp(32'hFFFF_FF80, 0, 0, 2);
        run(0, 2'd0, 1, 32'h2001, 32'h0);

        exp_beat(0, 32'h7004, 4'b1111, 32'h0, 32'hCAFE_F00D, 0);
        exp_rsp(32'hCAFE_F00D, 0, 0, 2);
        run(0, 2'd2, 0, 32'h7004, 32'h0);

        exp_beat(1, 32'h5000, 4'b1100, 32'h1234_0000, 32'h0, 0);
        exp_rsp(32'h0, 0, 0, 2);
        run(1, 2'd1, 0, 32'h5002, 32'h0000_1234);

        exp_beat(1, 32'h4000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 3);
        exp_rsp(32'h0, 0, 0, 5);
        run(1, 2'd2, 0, 32'h4000, 32'hDEAD_BEEF);

        exp_rsp(32'h0, 1, 0, 1);
        run(0, 2'd3, 0, 32'h0000_0100, 32'h0);
        exp_rsp(32'h0, 0, 1, 1);
        run(1, 2'd3, 0, 32'h0000_0108, 32'h1111_2222);

`ifdef MEM_MISALIGN_SPLIT_EN
        exp_beat(0, 32'h3000, 4'b1100, 32'h0, 32'h5566_7788, 0);
        exp_beat(0, 32'h3004, 4'b0011, 32'h0, 32'h1122_3344, 0);
        exp_rsp(32'h3344_5566, 0, 0, 3);
        run(0, 2'd2, 0, 32'h3002, 32'h0);

        exp_beat(1, 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_AABB, 32'h0, 0);
        exp_beat(1, 32'h0000_0000, 4'b0011, 32'hCCDD_AABB, 32'h0, 0);
        exp_rsp(32'h0, 0, 0, 3);
        run(1, 2'd2, 0, 32'hFFFF_FFFE, 32'hAABB_CCDD);

        exp_beat(0, 32'h2000, 4'b0110, 32'h0, 32'h00F0_0100, 0);
        exp_rsp(32'hFFFF_F001, 0, 0, 2);
        run(0, 2'd1, 1, 32'h2001, 32'h0);

        exp_beat(0, 32'h2000, 4'b1000, 32'h0, 32'hAA00_0000, 0);
        exp_beat(0, 32'h2004, 4'b0001, 32'h0, 32'h0000_00BB, 1);
        exp_rsp(32'h0000_BBAA, 0, 0, 4);
        run(0, 2'd1, 0, 32'h2003, 32'h0);
`else
        exp_rsp(32'h0, 1, 0, 1);
        run(0, 2'd2, 0, 32'h3002, 32'h0);
        exp_rsp(32'h0, 0, 1, 1);
        run(1, 2'd2, 0, 32'hFFFF_FFFE, 32'hAABB_CCDD);
        exp_rsp(32'h0, 1, 0, 1);
        run(0, 2'd1, 1, 32'h2001, 32'h0);
        exp_rsp(32'h0, 1, 0, 1);
        run(0, 2'd1, 0, 32'h2003, 32'h0);
`endif

        // Reset in the middle of a stalled beat, then the held request is re-issued.
        begin
            bit seen;
            logic [31:0] target;
            seen = 0;
`ifdef MEM_MISALIGN_SPLIT_EN
            target = 32'h7000;
            exp_beat(1, 32'h6FFC, 4'b1100, 32'h3344_1122, 32'h0, 0);
            exp_beat(1, 32'h7000, 4'b0011, 32'h3344_1122, 32'h0, 6);
            start_req(1, 2'd2, 0, 32'h6FFE, 32'h1122_3344);
`else
            target = 32'h6000;
            exp_beat(1, 32'h6000, 4'b1111, 32'h1122_3344, 32'h0, 6);
            start_req(1, 2'd2, 0, 32'h6000, 32'h1122_3344);
`endif
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (bus_valid && bus_addr == target) begin
                    seen = 1;
                    break;
                end
            end
            chk("reset_target_beat_seen", {31'd0, seen}, 32'd1);
            @(negedge clk);
            #2 reset = 1'b1;
            #1;
            chk("midreset_bus_valid", {31'd0, bus_valid}, 32'd0);
            chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            beat_q.delete();
            waited = 0;
            bus_ready = 1'b0;
            @(negedge clk);
            chk("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
            reset = 1'b0;
            chk("release_req_ready", {31'd0, req_ready}, 32'd1);
`ifdef MEM_MISALIGN_SPLIT_EN
            exp_beat(1, 32'h6FFC, 4'b1100, 32'h3344_1122, 32'h0, 0);
            exp_beat(1, 32'h7000, 4'b0011, 32'h3344_1122, 32'h0, 0);
            exp_rsp(32'h0, 0, 0, 3);
`else
            exp_beat(1, 32'h6000, 4'b1111, 32'h1122_3344, 32'h0, 0);
            exp_rsp(32'h0, 0, 0, 2);
`endif
            wait_rsp();
        end

        repeat (3) @(negedge clk);
        chk("beats_left", 32'(beat_q.size()), 32'd0);
        chk("rsps_left", 32'(rsp_q.size()), 32'd0);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised MEM-stage data-memory access unit for the pipelined MIPS core. Accepts one load/store per request from the MEM stage, generates byte strobes and lane-aligned write data for a DATA_W-wide memory bus, and splits accesses that cross a bus-word boundary into two beats. Extends load results (signed/unsigned) and stalls the pipeline until the access completes, absorbing variable memory latency through a valid/ready bus handshake.

## Interface
- DATA_W, 32, bus and data width in bits; 32 or 64. NB = DATA_W/8 byte lanes.
- ADDR_W, 32, byte-address width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM stage holds a load/store; held until rsp_valid.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- req_ready  out  1  unit idle; request accepted on edge with req_valid & req_ready.
- stall  out  1  = req_valid & ~rsp_valid.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and exceptions.
- exc_adel / exc_ades  out  1 each  load / store address exception; meaningful only with rsp_valid.
- bus_valid  out  1  beat request.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_W  NB-aligned beat address.
- bus_be  out  NB  byte strobes, lane i = bits 8i+7:8i (little-endian).
- bus_wdata  out  DATA_W  lane-aligned write data.
- bus_ready  in  1  beat completes on edge with bus_valid & bus_ready.
- bus_rdata  in  DATA_W  read data, valid in the cycle bus_ready is high on a read beat.

## Operation
- FSM: IDLE, BEAT0, BEAT1, RESP. req_ready = (state==IDLE).
- Accept in IDLE: capture request. bytes = 1<<req_size; off = addr mod NB.
- Illegal: size 11 with DATA_W=32 -> always exception. Misaligned (addr mod bytes != 0) -> see Configuration.
- Exception: go RESP, no bus activity, exc_adel (load) or exc_ades (store) set.
- Otherwise go BEAT0. be_full = ((1<<bytes)-1) << off over 2·NB lanes; wdata rotated left by off bytes.
- BEAT0: bus_addr = addr & ~(NB-1), bus_be = be_full[NB-1:0]. On handshake: if be_full[2NB-1:NB]==0 go RESP, else go BEAT1.
- BEAT1: bus_addr = BEAT0 address + NB, modulo 2^ADDR_W (wraps to 0); bus_be = be_full[2NB-1:NB]; same rotated wdata.
- Reads: latch bus_rdata each read handshake; assemble {beat1,beat0} lanes, shift right by off bytes, truncate to bytes, zero- or sign-extend per req_signed.
- RESP: rsp_valid=1 for one cycle, then IDLE. Pipeline advances on that edge.
- bus_valid/bus_addr/bus_be/bus_wdata/bus_we held stable while bus_valid & ~bus_ready.

## Timing
- Reset: state IDLE; all outputs 0 except req_ready=1; stall follows req_valid.
- Reset mid-access: bus_valid drops asynchronously, beat abandoned, no rsp_valid; request re-issued after release.
- Single beat, bus_ready tied 1: accept edge T, bus_valid cycle T+1, rsp_valid cycle T+2.
- Split, bus_ready tied 1: rsp_valid cycle T+3. Each bus_ready-low cycle adds one.
- Exception: rsp_valid cycle T+1.
- All outputs except stall are registered.

## Configuration
- MEM_MISALIGN_SPLIT_EN defined: misaligned legal-size accesses are performed (split when crossing an NB boundary); exc_adel/exc_ades only for illegal size.
- Undefined: any misaligned access raises exc_adel/exc_ades with no bus beat; BEAT1 unreachable and may be optimised out.

## Test plan
- DATA_W=32, SB addr 0x1003 wdata 0xAB -> bus_addr 0x1000, be 1000, wdata 0xAB000000, rsp_valid at T+2.
- LH addr 0x2002 read 0x8001_1234 -> rsp_rdata 0xFFFF8001; LHU same -> 0x00008001.
- Split enabled: LW 0x3002, beat0 0x3000 be 1100 read 0x55667788, beat1 0x3004 be 0011 read 0x11223344 -> rsp_rdata 0x33445566 at T+3; disabled: exc_adel=1, no bus_valid, rsp_valid at T+1.
- SW 0x4000 with bus_ready low 3 cycles -> bus signals stable, stall high, rsp_valid at T+5.
- Split enabled: SW 0xFFFFFFFE wdata 0xAABBCCDD -> beat0 0xFFFFFFFC be 1100 wdata 0xCCDDAABB, beat1 0x00000000 be 0011.
- Reset asserted during BEAT1 -> bus_valid 0 same cycle, no rsp_valid, req_ready 1 after release.
